div16x8_seq: RTL and testbench

//   Sequential radix-2 restoring divider, the inverse datapath of the 8x8 shift-add multiplier.

---
 rtl/div16x8_seq_if.sv | 30 +++
 rtl/div16x8_seq.sv | 170 +++++++++++++++++
 tb/tb_div16x8_seq.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/div16x8_seq_if.sv
// Handshake and result bundle for the sequential divider.
// Parameters DIVIDEND_W and DIVISOR_W must match the attached div16x8_seq instance.
//   master : requester side, which drives start, dataa and datab.
//   slave  : divider side, which drives busy, done_flag, div_by_zero,
//            quotient, remainder, state_out and seg_out.
interface div16x8_seq_if #(
    parameter int unsigned DIVIDEND_W = 16,
    parameter int unsigned DIVISOR_W  = 8
);
    logic                  start;
    logic [DIVIDEND_W-1:0] dataa;
    logic [DIVISOR_W-1:0]  datab;
    logic                  busy;
    logic                  done_flag;
    logic                  div_by_zero;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic [2:0]            state_out;
    logic [6:0]            seg_out;

    modport master (
        output start, dataa, datab,
        input  busy, done_flag, div_by_zero, quotient, remainder, state_out, seg_out
    );

    modport slave (
        input  start, dataa, datab,
        output busy, done_flag, div_by_zero, quotient, remainder, state_out, seg_out
    );
endinterface

// File: rtl/div16x8_seq.sv
// Sequential radix-2 restoring divider: dataa / datab, one quotient bit per clock.
// Ports:
//   clk     rising-edge clock
//   aclr_n  asynchronous active-low reset
//   bus     div16x8_seq_if.slave
//           in : start, dataa (dividend), datab (divisor)
//           out: busy, done_flag, div_by_zero, quotient, remainder,
//                state_out (IDLE=0, CALC=1, DONE=2, ERR=3), seg_out {a..g}
// Optional build macro DIV_SEG_DISPLAY_EN: when defined, seg_out is a registered
// seven-segment decode of state_out; otherwise seg_out is tied low.
module div16x8_seq #(
    parameter int unsigned DIVIDEND_W = 16,
    parameter int unsigned DIVISOR_W  = 8
) (
    input  logic           clk,
    input  logic           aclr_n,
    div16x8_seq_if.slave   bus
);
    localparam int unsigned CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
    localparam int unsigned REM_W = DIVISOR_W + 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CALC = 3'd1,
        DONE = 3'd2,
        ERR  = 3'd3
    } state_t;

    state_t                state_q, state_d;
    logic [DIVISOR_W-1:0]  divisor_q, divisor_d;
    logic [REM_W-1:0]      rem_acc_q, rem_acc_d;
    logic [DIVIDEND_W-1:0] q_acc_q, q_acc_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  busy_q, busy_d;
    logic                  done_flag_q, done_flag_d;
    logic                  div_by_zero_q, div_by_zero_d;
    logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
    logic [DIVISOR_W-1:0]  remainder_q, remainder_d;

    // One restoring iteration: shift {rem,q} left, trial-subtract the divisor.
    logic [REM_W-1:0]      rem_shift;
    logic [REM_W:0]        trial;
    logic                  fits;
    logic [REM_W-1:0]      rem_next;
    logic [DIVIDEND_W-1:0] q_next;

    always_comb begin
        rem_shift = {rem_acc_q[DIVISOR_W-1:0], q_acc_q[DIVIDEND_W-1]};
        // Full-width subtract; rem_acc never reaches the divisor, so the top bit is a clean borrow.
        trial     = {rem_acc_q, q_acc_q[DIVIDEND_W-1]} - (REM_W+1)'(divisor_q);
        fits      = ~trial[REM_W];
        rem_next  = fits ? trial[REM_W-1:0] : rem_shift;
        q_next    = {q_acc_q[DIVIDEND_W-2:0], fits};
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        divisor_d     = divisor_q;
        rem_acc_d     = rem_acc_q;
        q_acc_d       = q_acc_q;
        count_d       = count_q;
        busy_d        = 1'b0;
        done_flag_d   = 1'b0;
        div_by_zero_d = div_by_zero_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.datab != '0) begin
                        divisor_d     = bus.datab;
                        rem_acc_d     = '0;
                        q_acc_d       = bus.dataa;
                        count_d       = '0;
                        div_by_zero_d = 1'b0;
                        busy_d        = 1'b1;
                        state_d       = CALC;
                    end else begin
                        // Error results are loaded here so they are valid alongside done_flag in ERR.
                        done_flag_d   = 1'b1;
                        div_by_zero_d = 1'b1;
                        quotient_d    = '1;
                        remainder_d   = bus.dataa[DIVISOR_W-1:0];
                        state_d       = ERR;
                    end
                end
            end
            CALC: begin
                rem_acc_d = rem_next;
                q_acc_d   = q_next;
                if (count_q == CNT_W'(DIVIDEND_W - 1)) begin
                    // Final iteration: publish results on the same edge that raises done_flag.
                    count_d     = '0;
                    done_flag_d = 1'b1;
                    quotient_d  = q_next;
                    remainder_d = rem_next[DIVISOR_W-1:0];
                    state_d     = DONE;
                end else begin
                    count_d = count_q + CNT_W'(1);
                    busy_d  = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q       <= IDLE;
            divisor_q     <= '0;
            rem_acc_q     <= '0;
            q_acc_q       <= '0;
            count_q       <= '0;
            busy_q        <= 1'b0;
            done_flag_q   <= 1'b0;
            div_by_zero_q <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
        end else begin
            state_q       <= state_d;
            divisor_q     <= divisor_d;
            rem_acc_q     <= rem_acc_d;
            q_acc_q       <= q_acc_d;
            count_q       <= count_d;
            busy_q        <= busy_d;
            done_flag_q   <= done_flag_d;
            div_by_zero_q <= div_by_zero_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done_flag   = done_flag_q;
    assign bus.div_by_zero = div_by_zero_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.state_out   = state_q;

`ifdef DIV_SEG_DISPLAY_EN
    // Seven-segment status digit, one cycle behind state_out.
    logic [6:0] seg_q, seg_d;

    always_comb begin
        seg_d = 7'b0000000;
        case (state_q)
            IDLE:    seg_d = 7'b1111110;
            CALC:    seg_d = 7'b0110000;
            DONE:    seg_d = 7'b1101101;
            ERR:     seg_d = 7'b1111001;
            default: seg_d = 7'b0000000;
        endcase
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) seg_q <= 7'b0000000;
        else         seg_q <= seg_d;
    end

    assign bus.seg_out = seg_q;
`else
    assign bus.seg_out = 7'b0000000;
`endif

endmodule

// File: tb/tb_div16x8_seq.sv
// Directed self-checking bench for div16x8_seq.
module tb_div16x8_seq;
    logic clk = 1'b0;
    logic aclr_n;
    int   total = 0;
    int   bad   = 0;

    div16x8_seq_if #(.DIVIDEND_W(16), .DIVISOR_W(8)) bus ();

    div16x8_seq #(.DIVIDEND_W(16), .DIVISOR_W(8)) dut (
        .clk    (clk),
        .aclr_n (aclr_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Launch one operation; lat = cycles from the sampling edge to done_flag (0 = timeout).
    task automatic run_op(input logic [15:0] a, input logic [7:0] b,
                          output int lat, output logic busy_seen);
        lat = 0;
        busy_seen = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.dataa = a;
        bus.datab = b;
        @(posedge clk);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) begin
                bus.start = 1'b0;
                bus.dataa = 16'hA5A5;
                bus.datab = 8'h3C;
            end
            if (bus.busy) busy_seen = 1'b1;
            if (bus.done_flag) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset;
        aclr_n    = 1'b0;
        bus.start = 1'b0;
        bus.dataa = 16'h0;
        bus.datab = 8'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        total++; if (bus.done_flag !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done_flag); end
        total++; if (bus.div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b want=0", bus.div_by_zero); end
        total++; if (bus.quotient !== 16'h0) begin bad++; $display("FAIL reset_q got=%h want=0000", bus.quotient); end
        total++; if (bus.remainder !== 8'h0) begin bad++; $display("FAIL reset_r got=%h want=00", bus.remainder); end
        total++; if (bus.state_out !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", bus.state_out); end
        total++; if (bus.seg_out !== 7'b0) begin bad++; $display("FAIL reset_seg got=%b want=0000000", bus.seg_out); end
        aclr_n = 1'b1;
    endtask

    task automatic test_basic;
        int lat;
        logic bs;
        run_op(16'h03E8, 8'h07, lat, bs);
        total++; if (lat !== 17) begin bad++; $display("FAIL basic_latency got=%0d want=17", lat); end
        total++; if (bus.quotient !== 16'h008E) begin bad++; $display("FAIL basic_q got=%h want=008e", bus.quotient); end
        total++; if (bus.remainder !== 8'h06) begin bad++; $display("FAIL basic_r got=%h want=06", bus.remainder); end
        total++; if (bus.div_by_zero !== 1'b0) begin bad++; $display("FAIL basic_dbz got=%b want=0", bus.div_by_zero); end
        total++; if (bs !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", bs); end
        @(negedge clk);
        total++; if (bus.done_flag !== 1'b0) begin bad++; $display("FAIL basic_pulse got=%b want=0", bus.done_flag); end
        total++; if (bus.quotient !== 16'h008E) begin bad++; $display("FAIL basic_hold got=%h want=008e", bus.quotient); end
        total++; if (bus.state_out !== 3'd0) begin bad++; $display("FAIL basic_idle got=%0d want=0", bus.state_out); end
    endtask

    task automatic test_boundary;
        int lat;
        logic bs;
        run_op(16'hFFFF, 8'h01, lat, bs);
        total++; if (lat !== 17) begin bad++; $display("FAIL max_latency got=%0d want=17", lat); end
        total++; if (bus.quotient !== 16'hFFFF) begin bad++; $display("FAIL max_q got=%h want=ffff", bus.quotient); end
        total++; if (bus.remainder !== 8'h00) begin bad++; $display("FAIL max_r got=%h want=00", bus.remainder); end
        run_op(16'h0005, 8'h09, lat, bs);
        total++; if (lat !== 17) begin bad++; $display("FAIL small_latency got=%0d want=17", lat); end
        total++; if (bus.quotient !== 16'h0000) begin bad++; $display("FAIL small_q got=%h want=0000", bus.quotient); end
        total++; if (bus.remainder !== 8'h05) begin bad++; $display("FAIL small_r got=%h want=05", bus.remainder); end
    endtask

    task automatic test_div_by_zero;
        int lat;
        logic bs;
        run_op(16'h1234, 8'h00, lat, bs);
        total++; if (lat !== 1) begin bad++; $display("FAIL dbz_latency got=%0d want=1", lat); end
        total++; if (bus.div_by_zero !== 1'b1) begin bad++; $display("FAIL dbz_flag got=%b want=1", bus.div_by_zero); end
        total++; if (bus.quotient !== 16'hFFFF) begin bad++; $display("FAIL dbz_q got=%h want=ffff", bus.quotient); end
        total++; if (bus.remainder !== 8'h34) begin bad++; $display("FAIL dbz_r got=%h want=34", bus.remainder); end
        total++; if (bus.state_out !== 3'd3) begin bad++; $display("FAIL dbz_state got=%0d want=3", bus.state_out); end
        total++; if (bs !== 1'b0) begin bad++; $display("FAIL dbz_busy got=%b want=0", bs); end
        @(negedge clk);
        total++; if (bus.div_by_zero !== 1'b1) begin bad++; $display("FAIL dbz_hold got=%b want=1", bus.div_by_zero); end
    endtask

    task automatic test_ignore_start;
        int ndone = 0;
        int first = 0;
        logic [15:0] q_at = 16'h0;
        logic [7:0]  r_at = 8'h0;
        @(negedge clk);
        bus.start = 1'b1; bus.dataa = 16'h03E8; bus.datab = 8'h07;
        @(posedge clk);
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n == 1) bus.start = 1'b0;
            if (n == 5) begin bus.start = 1'b1; bus.dataa = 16'h0100; bus.datab = 8'h03; end
            if (n == 6) bus.start = 1'b0;
            if (bus.done_flag) begin
                ndone++;
                if (first == 0) begin first = n; q_at = bus.quotient; r_at = bus.remainder; end
            end
        end
        total++; if (ndone !== 1) begin bad++; $display("FAIL ignore_count got=%0d want=1", ndone); end
        total++; if (first !== 17) begin bad++; $display("FAIL ignore_latency got=%0d want=17", first); end
        total++; if (q_at !== 16'h008E) begin bad++; $display("FAIL ignore_q got=%h want=008e", q_at); end
        total++; if (r_at !== 8'h06) begin bad++; $display("FAIL ignore_r got=%h want=06", r_at); end
    endtask

    task automatic test_reset_abort;
        int ndone = 0;
        int lat;
        logic bs;
        @(negedge clk);
        bus.start = 1'b1; bus.dataa = 16'h03E8; bus.datab = 8'h07;
        @(posedge clk);
        for (int n = 1; n <= 25; n++) begin
            @(negedge clk);
            if (n == 1) bus.start = 1'b0;
            if (n == 8) begin
                aclr_n = 1'b0;
                #1;
                total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", bus.busy); end
                total++; if (bus.quotient !== 16'h0) begin bad++; $display("FAIL abort_q got=%h want=0000", bus.quotient); end
                total++; if (bus.remainder !== 8'h0) begin bad++; $display("FAIL abort_r got=%h want=00", bus.remainder); end
                total++; if (bus.state_out !== 3'd0) begin bad++; $display("FAIL abort_state got=%0d want=0", bus.state_out); end
                total++; if (bus.seg_out !== 7'b0) begin bad++; $display("FAIL abort_seg got=%b want=0000000", bus.seg_out); end
            end
            if (n == 10) aclr_n = 1'b1;
            if (bus.done_flag) ndone++;
        end
        total++; if (ndone !== 0) begin bad++; $display("FAIL abort_done got=%0d want=0", ndone); end
        run_op(16'h1234, 8'h12, lat, bs);
        total++; if (lat !== 17) begin bad++; $display("FAIL abort_rerun_latency got=%0d want=17", lat); end
        total++; if (bus.quotient !== 16'h0102) begin bad++; $display("FAIL abort_rerun_q got=%h want=0102", bus.quotient); end
        total++; if (bus.remainder !== 8'h10) begin bad++; $display("FAIL abort_rerun_r got=%h want=10", bus.remainder); end
    endtask

    task automatic test_back_to_back;
        int ndone = 0;
        int d1 = 0;
        int d2 = 0;
        logic [15:0] q2 = 16'h0;
        logic [7:0]  r2 = 8'hFF;
        @(negedge clk);
        bus.start = 1'b1; bus.dataa = 16'hFFFF; bus.datab = 8'h01;
        @(posedge clk);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 19) bus.start = 1'b0;
            if (n == 18) begin
                total++; if (bus.state_out !== 3'd0) begin bad++; $display("FAIL b2b_gap got=%0d want=0", bus.state_out); end
            end
            if (bus.done_flag) begin
                ndone++;
                if (ndone == 1) d1 = n;
                if (ndone == 2) begin d2 = n; q2 = bus.quotient; r2 = bus.remainder; end
            end
        end
        total++; if (ndone !== 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", ndone); end
        total++; if (d1 !== 17) begin bad++; $display("FAIL b2b_first got=%0d want=17", d1); end
        total++; if (d2 !== 35) begin bad++; $display("FAIL b2b_second got=%0d want=35", d2); end
        total++; if (q2 !== 16'hFFFF) begin bad++; $display("FAIL b2b_q got=%h want=ffff", q2); end
        total++; if (r2 !== 8'h00) begin bad++; $display("FAIL b2b_r got=%h want=00", r2); end
    endtask

    task automatic test_seg;
        logic [6:0] want1, want2, want17, want18, want19;
`ifdef DIV_SEG_DISPLAY_EN
        want1 = 7'b1111110; want2 = 7'b0110000; want17 = 7'b0110000;
        want18 = 7'b1101101; want19 = 7'b1111110;
`else
        want1 = 7'b0; want2 = 7'b0; want17 = 7'b0; want18 = 7'b0; want19 = 7'b0;
`endif
        @(negedge clk);
        bus.start = 1'b1; bus.dataa = 16'h03E8; bus.datab = 8'h07;
        @(posedge clk);
        for (int n = 1; n <= 19; n++) begin
            @(negedge clk);
            if (n == 1) begin
                bus.start = 1'b0;
                total++; if (bus.state_out !== 3'd1) begin bad++; $display("FAIL seg_state_calc got=%0d want=1", bus.state_out); end
                total++; if (bus.seg_out !== want1) begin bad++; $display("FAIL seg_n1 got=%b want=%b", bus.seg_out, want1); end
            end
            if (n == 2) begin
                total++; if (bus.seg_out !== want2) begin bad++; $display("FAIL seg_n2 got=%b want=%b", bus.seg_out, want2); end
            end
            if (n == 17) begin
                total++; if (bus.state_out !== 3'd2) begin bad++; $display("FAIL seg_state_done got=%0d want=2", bus.state_out); end
                total++; if (bus.seg_out !== want17) begin bad++; $display("FAIL seg_n17 got=%b want=%b", bus.seg_out, want17); end
            end
            if (n == 18) begin
                total++; if (bus.seg_out !== want18) begin bad++; $display("FAIL seg_n18 got=%b want=%b", bus.seg_out, want18); end
            end
            if (n == 19) begin
                total++; if (bus.seg_out !== want19) begin bad++; $display("FAIL seg_n19 got=%b want=%b", bus.seg_out, want19); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_div_by_zero();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        test_seg();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
